// File: rtl/system_top_cmul_pkg.sv
// Shared widths and arithmetic helpers for the complex-multiply pipeline.
package system_top_cmul_pkg;

    localparam int DEF_A_W   = 16;
    localparam int DEF_B_W   = 11;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_SHIFT = 10;

    // Half an output LSB at the given shift, for round-half-up.
    function automatic logic signed [63:0] rnd_const(input int shift);
        logic signed [63:0] one;
        one = 64'sd1;
        return one <<< (shift - 1);
    endfunction

    // Clamp a value to the signed range of an out_w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/system_top_cmul_pipe_if.sv
// Beat-level bus of the complex-multiply pipeline.
// Handshake: a beat moves across a port on a cycle where its vld and rdy are
// both 1; the producer keeps vld and data stable until that cycle, and rdy
// may depend combinationally on the consumer's state.
interface system_top_cmul_pipe_if
    import system_top_cmul_pkg::*;
#(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic                    in_vld;
    logic                    in_rdy;
    logic signed [A_W-1:0]   a_re;
    logic signed [A_W-1:0]   a_im;
    logic signed [B_W-1:0]   b_re;
    logic signed [B_W-1:0]   b_im;
    logic                    conj;
    logic                    out_vld;
    logic                    out_rdy;
    logic signed [OUT_W-1:0] y_re;
    logic signed [OUT_W-1:0] y_im;
    logic                    ovf;

    modport master (
        output in_vld, a_re, a_im, b_re, b_im, conj, out_rdy,
        input  in_rdy, out_vld, y_re, y_im, ovf
    );

    modport slave (
        input  in_vld, a_re, a_im, b_re, b_im, conj, out_rdy,
        output in_rdy, out_vld, y_re, y_im, ovf
    );
endinterface

// File: rtl/system_top_cmul_rndsat.sv
// Combinational round-half-up, arithmetic right shift and saturation.
module system_top_cmul_rndsat
    import system_top_cmul_pkg::*;
#(
    parameter int IN_W  = 28,
    parameter int SHIFT = DEF_SHIFT,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);
    logic signed [63:0] wide;
    logic signed [63:0] shifted;
    logic signed [63:0] clamped;

    // Work at 64 bits so the rounding add can never wrap.
    always_comb begin
        wide    = {{(64-IN_W){din[IN_W-1]}}, din};
        shifted = (wide + rnd_const(SHIFT)) >>> SHIFT;
        clamped = saturate(shifted, OUT_W);
        dout    = clamped[OUT_W-1:0];
        sat     = (clamped != shifted);
    end
endmodule

// File: rtl/system_top_cmul_pipe.sv
// Three-stage complex multiplier y = A*B or A*conj(B), rounded and saturated.
// The whole pipe advances together on en; there is no skid buffer, so
// in_rdy is just en.
module system_top_cmul_pipe
    import system_top_cmul_pkg::*;
#(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input logic                 ap_clk,
    input logic                 ap_rst,
    system_top_cmul_pipe_if.slave bus
);
    localparam int P_W = A_W + B_W;
    localparam int S_W = P_W + 1;

    logic en;
    logic v1, v2, v3;

    logic signed [A_W-1:0] s1_ar, s1_ai;
    logic signed [B_W-1:0] s1_br, s1_bi;
    logic                  s1_conj;

    logic signed [P_W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic                  s2_conj;

    logic signed [S_W-1:0]   sum_re, sum_im;
    logic signed [OUT_W-1:0] rs_re, rs_im;
    logic                    sat_re, sat_im;

    logic signed [OUT_W-1:0] y_re_q, y_im_q;
    logic                    ovf_q;

    assign en          = ~v3 | bus.out_rdy;
    assign bus.in_rdy  = en;
    assign bus.out_vld = v3;
    assign bus.y_re    = y_re_q;
    assign bus.y_im    = y_im_q;
    assign bus.ovf     = ovf_q;

    // S1: capture operands and conj of an accepted beat.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            v1      <= 1'b0;
            s1_ar   <= '0;
            s1_ai   <= '0;
            s1_br   <= '0;
            s1_bi   <= '0;
            s1_conj <= 1'b0;
        end else if (en) begin
            v1      <= bus.in_vld;
            s1_ar   <= bus.a_re;
            s1_ai   <= bus.a_im;
            s1_br   <= bus.b_re;
            s1_bi   <= bus.b_im;
            s1_conj <= bus.conj;
        end
    end

    // S2: the four full-precision partial products.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            v2      <= 1'b0;
            p_rr    <= '0;
            p_ii    <= '0;
            p_ri    <= '0;
            p_ir    <= '0;
            s2_conj <= 1'b0;
        end else if (en) begin
            v2      <= v1;
            p_rr    <= P_W'(s1_ar) * P_W'(s1_br);
            p_ii    <= P_W'(s1_ai) * P_W'(s1_bi);
            p_ri    <= P_W'(s1_ar) * P_W'(s1_bi);
            p_ir    <= P_W'(s1_ai) * P_W'(s1_br);
            s2_conj <= s1_conj;
        end
    end

    // One extra bit on the sums keeps the add/subtract exact.
    always_comb begin
        if (s2_conj) begin
            sum_re = S_W'(p_rr) + S_W'(p_ii);
            sum_im = S_W'(p_ir) - S_W'(p_ri);
        end else begin
            sum_re = S_W'(p_rr) - S_W'(p_ii);
            sum_im = S_W'(p_ri) + S_W'(p_ir);
        end
    end

    system_top_cmul_rndsat #(.IN_W(S_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_re (
        .din  (sum_re),
        .dout (rs_re),
        .sat  (sat_re)
    );

    system_top_cmul_rndsat #(.IN_W(S_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_im (
        .din  (sum_im),
        .dout (rs_im),
        .sat  (sat_im)
    );

    // S3: register the rounded result; only a valid beat replaces the outputs.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            v3     <= 1'b0;
            y_re_q <= '0;
            y_im_q <= '0;
            ovf_q  <= 1'b0;
        end else if (en) begin
            v3 <= v2;
            if (v2) begin
                y_re_q <= rs_re;
                y_im_q <= rs_im;
                ovf_q  <= sat_re | sat_im;
            end
        end
    end
endmodule

// File: tb/tb_system_top_cmul_pipe.sv
// Directed bench for system_top_cmul_pipe with hand-computed expectations.
module tb_system_top_cmul_pipe;
    logic ap_clk;
    logic ap_rst;

    int n_pass;
    int n_chk;

    system_top_cmul_pipe_if #(.A_W(16), .B_W(11), .OUT_W(16)) bus ();

    system_top_cmul_pipe #(.A_W(16), .B_W(11), .OUT_W(16), .SHIFT(10)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input int ar, input int ai, input int br, input int bi,
                         input logic cj);
        bus.a_re = 16'(ar);
        bus.a_im = 16'(ai);
        bus.b_re = 11'(br);
        bus.b_im = 11'(bi);
        bus.conj = cj;
    endtask

    // One beat through an idle pipe: latency and result.
    task automatic run_single(input string tag, input int ar, input int ai,
                              input int br, input int bi, input logic cj,
                              input int exp_re, input int exp_im, input int exp_ovf);
        int lat;
        bus.out_rdy = 1'b1;
        drive(ar, ai, br, bi, cj);
        bus.in_vld = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.in_vld = 1'b0;
        lat = 1;
        while (!bus.out_vld && lat < 10) begin
            @(posedge ap_clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_re"}, 32'(bus.y_re), exp_re);
        check({tag, "_im"}, 32'(bus.y_im), exp_im);
        check({tag, "_ovf"}, 32'(bus.ovf), exp_ovf);
    endtask

    logic [32:0] exp_q[$];

    initial begin
        int sent, got, cyc, first_cyc, tenth_cyc, stall_left;
        int bad_rdy, bad_hold, stale;
        logic acc;
        logic [32:0] e;
        logic signed [15:0] held_re, held_im;
        logic held_ovf;
        int ar, ai;

        n_pass = 0;
        n_chk  = 0;
        ap_rst = 1'b1;
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        drive(0, 0, 0, 0, 1'b0);

        // Reset state
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_out_vld", 32'(bus.out_vld), 0);
        check("rst_y_re", 32'(bus.y_re), 0);
        check("rst_y_im", 32'(bus.y_im), 0);
        check("rst_ovf", 32'(bus.ovf), 0);
        ap_rst = 1'b0;
        #1;
        check("rst_in_rdy", 32'(bus.in_rdy), 1);

        // Directed single beats
        run_single("basic", 1000, -2000, 512, 256, 1'b0, 1000, -750, 0);
        run_single("conj", 1000, -2000, 512, 256, 1'b1, 0, -1250, 0);
        run_single("sat", -32768, -32768, -1024, 1023, 1'b0, 32767, 32, 1);
        run_single("rnd_pos", 3, 0, 512, 0, 1'b0, 2, 0, 0);
        run_single("rnd_neg", -3, 0, 512, 0, 1'b0, -1, 0, 0);

        // Streaming 14 beats; stall for 4 cycles once 10 results are out.
        // Even beats: B=(-1024,0) -> y=(-ar,-ai). Odd beats, conj:
        // B=(0,-1024) -> y=(-ai, ar).
        @(posedge ap_clk);
        #1;
        sent = 0; got = 0; cyc = 0; first_cyc = 0; tenth_cyc = 0;
        stall_left = -1; bad_rdy = 0; bad_hold = 0;
        held_re = '0; held_im = '0; held_ovf = 1'b0;
        while (got < 14 && cyc < 300) begin
            if (got == 10 && stall_left < 0) begin
                stall_left = 4;
                held_re  = bus.y_re;
                held_im  = bus.y_im;
                held_ovf = bus.ovf;
            end
            bus.out_rdy = (stall_left > 0) ? 1'b0 : 1'b1;
            if (sent < 14) begin
                ar = (sent + 1) * 100;
                ai = -(sent + 1) * 7;
                if (sent % 2 == 0) drive(ar, ai, -1024, 0, 1'b0);
                else drive(ar, ai, 0, -1024, 1'b1);
                bus.in_vld = 1'b1;
            end else begin
                bus.in_vld = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                if (bus.in_rdy) bad_rdy++;
                if (!bus.out_vld || bus.y_re !== held_re || bus.y_im !== held_im ||
                    bus.ovf !== held_ovf) bad_hold++;
                stall_left--;
            end
            acc = bus.in_vld & bus.in_rdy;
            if (acc) begin
                if (sent % 2 == 0) exp_q.push_back({16'(-ar), 16'(-ai), 1'b0});
                else exp_q.push_back({16'(-ai), 16'(ar), 1'b0});
            end
            if (bus.out_vld && bus.out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_re", 32'(bus.y_re), 32'(signed'(e[32:17])));
                    check("stream_im", 32'(bus.y_im), 32'(signed'(e[16:1])));
                    check("stream_ovf", 32'(bus.ovf), 32'(e[0]));
                end
                if (got == 0) first_cyc = cyc;
                if (got == 9) tenth_cyc = cyc;
                got++;
            end
            @(posedge ap_clk);
            #1;
            cyc++;
            if (acc) sent++;
        end
        bus.in_vld = 1'b0;
        bus.out_rdy = 1'b1;
        check("stream_count", got, 14);
        check("stream_leftover", exp_q.size(), 0);
        check("stream_consecutive", tenth_cyc - first_cyc, 9);
        check("stall_in_rdy", bad_rdy, 0);
        check("stall_hold", bad_hold, 0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            drive((i + 1) * 100, 0, -1024, 0, 1'b0);
            bus.in_vld = 1'b1;
            @(posedge ap_clk);
            #1;
        end
        bus.in_vld = 1'b0;
        check("pre_rst_out_vld", 32'(bus.out_vld), 1);
        ap_rst = 1'b1;
        #1;
        check("mid_rst_out_vld", 32'(bus.out_vld), 0);
        check("mid_rst_y_re", 32'(bus.y_re), 0);
        check("mid_rst_ovf", 32'(bus.ovf), 0);
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        #1;
        check("post_rst_in_rdy", 32'(bus.in_rdy), 1);
        stale = 0;
        repeat (6) begin
            @(posedge ap_clk);
            #1;
            if (bus.out_vld) stale++;
        end
        check("post_rst_stale", stale, 0);
        run_single("post_rst", 1000, -2000, 512, 256, 1'b0, 1000, -750, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/system_top_cmul_pipe.md
SYSTEM_TOP_CMUL_PIPE -- requirements
Module: system_top_cmul_pipe

Interface
REQ-001 Parameter A_W, default 16: signed width of operand A, real and imaginary.
REQ-002 Parameter B_W, default 11: signed width of operand B, real and imaginary.
REQ-003 Parameter OUT_W, default 16: signed width of each output component.
REQ-004 Parameter SHIFT, default 10: right shift applied to the full-precision result; legal range 1..A_W+B_W.
REQ-005 ap_clk  in  1: single clock; all state SHALL update on its rising edge.
REQ-006 ap_rst  in  1: reset, asynchronous and active-high.
REQ-007 in_vld  in  1: input beat valid.
REQ-008 in_rdy  out  1: block accepts a beat on a cycle where in_vld=1 and in_rdy=1.
REQ-009 a_re, a_im  in  A_W each: operand A, signed.
REQ-010 b_re, b_im  in  B_W each: operand B, signed.
REQ-011 conj  in  1: when 1, the beat computes A*conj(B); sampled with the beat.
REQ-012 out_vld  out  1: result valid.
REQ-013 out_rdy  in  1: downstream accepts the result on a cycle where out_vld=1 and out_rdy=1.
REQ-014 y_re, y_im  out  OUT_W each: rounded, saturated product components.
REQ-015 ovf  out  1: set when y_re or y_im of this beat was saturated.

Function
REQ-016 The block SHALL be a 3-stage pipeline: S1 registers the operands and conj; S2 registers the four partial products ar*br, ai*bi, ar*bi, ai*br (each A_W+B_W bits, signed); S3 registers the sums and the rounded/saturated outputs.
REQ-017 Latency SHALL be exactly 3 ap_clk cycles from acceptance to out_vld with no stall.
REQ-018 Non-conj: re=ar*br-ai*bi, im=ar*bi+ai*br; conj: re=ar*br+ai*bi, im=ai*br-ar*bi.
REQ-019 Sums SHALL use A_W+B_W+1 bits, so no intermediate overflow is possible.
REQ-020 Rounding: add 2^(SHIFT-1), then arithmetic right shift by SHIFT (round half toward +infinity).
REQ-021 Saturation: a shifted value above 2^(OUT_W-1)-1 or below -2^(OUT_W-1) SHALL clamp to that limit; ovf=1 for the beat if either component clamps.
REQ-022 Pipeline enable en = ~out_vld | out_rdy; all stage registers and stage valid bits SHALL advance only when en=1.
REQ-023 in_rdy SHALL equal en, combinationally; there is no skid buffer.
REQ-024 While out_vld=1 and out_rdy=0, y_re, y_im and ovf SHALL hold stable.
REQ-025 Stage valid bits SHALL be tracked per stage; bubbles SHALL propagate, and back-to-back beats SHALL sustain 1 result per cycle when out_rdy=1.
REQ-026 Data registers without a valid beat SHALL NOT be observed; outputs are qualified only by out_vld.

Reset
REQ-027 ap_rst=1 SHALL asynchronously clear all stage valid bits, out_vld, y_re, y_im and ovf to 0.
REQ-028 Reset mid-stream SHALL discard every beat in flight; the first beat accepted after reset deassertion appears exactly 3 cycles later.
REQ-029 in_rdy SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 Shared package system_top_cmul_pkg SHALL hold the default widths, the rounding constant function and the saturate function.
REQ-031 One sub-module system_top_cmul_rndsat (parameterised in-width, SHIFT and OUT_W; combinational round and saturate) SHALL be instantiated twice, once for re and once for im.

Verification
REQ-032 A=(1000,-2000), B=(512,256), conj=0 -> after 3 cycles y=(1000,-750), ovf=0.
REQ-033 Same operands, conj=1 -> y=(0,-1250), ovf=0.
REQ-034 A=(-32768,-32768), B=(-1024,1023), conj=0 -> y_re=32767, y_im=32, ovf=1.
REQ-035 Rounding checks: A=(3,0), B=(512,0) -> y_re=2; A=(-3,0), B=(512,0) -> y_re=-1.
REQ-036 Streaming and stall: 10 back-to-back beats with out_rdy=1 -> 10 consecutive results. Then out_rdy=0 for 4 cycles -> in_rdy=0 and outputs held. Then out_rdy=1 -> remaining beats come out in order with no loss or duplication.
REQ-037 Reset mid-stream: ap_rst pulsed with 3 beats in flight -> out_vld=0 immediately, no stale beat emerges, and the next beat appears 3 cycles after acceptance.
